// File: rtl/e_mdu_iter.sv
//==============================================================================
// Module      : e_mdu_iter
// Description : Iterative multiply/divide unit with HI/LO accumulate ops.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module e_mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_ZERO_Q  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             start
);

  localparam int c_CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_CNT_DIV = c_CW'(WIDTH);
  localparam logic [c_CW-1:0] c_CNT_MUL = c_CW'(MULT_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam bit              c_DZ_Q    = (DIV_ZERO_Q != 0);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MFHI  = 4'd5;
  localparam logic [3:0] c_OP_MFLO  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;
  localparam logic [3:0] c_OP_MADD  = 4'd9;
  localparam logic [3:0] c_OP_MADDU = 4'd10;
  localparam logic [3:0] c_OP_MSUB  = 4'd11;
  localparam logic [3:0] c_OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [2*WIDTH-1:0] r_temp;
  logic [WIDTH-1:0]   r_rem, r_quo, r_div;
  logic               r_neg_q, r_neg_r, r_dzero, r_busy;
  logic [c_CW-1:0]    r_cnt;

  logic w_is_mul, w_is_div, w_signed, w_acc_add, w_acc_sub, w_accept, w_commit;

  assign w_is_div  = (op == c_OP_DIV) || (op == c_OP_DIVU);
  assign w_is_mul  = (op == c_OP_MULT) || (op == c_OP_MULTU) || (op == c_OP_MADD) ||
                     (op == c_OP_MADDU) || (op == c_OP_MSUB) || (op == c_OP_MSUBU);
  assign w_signed  = (op == c_OP_MULT) || (op == c_OP_DIV) ||
                     (op == c_OP_MADD) || (op == c_OP_MSUB);
  assign w_acc_add = (op == c_OP_MADD) || (op == c_OP_MADDU);
  assign w_acc_sub = (op == c_OP_MSUB) || (op == c_OP_MSUBU);

  assign start  = w_is_mul || w_is_div;
  assign busy   = r_busy;
  assign result = (op == c_OP_MFHI) ? r_hi : (op == c_OP_MFLO) ? r_lo : '0;

  // Single 2W x 2W multiplier; operands are pre-extended according to signedness
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_hilo, w_mul_res;
  assign w_a_ext   = w_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign w_b_ext   = w_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_hilo    = {r_hi, r_lo};
  assign w_mul_res = w_acc_add ? (w_hilo + w_prod) :
                     w_acc_sub ? (w_hilo - w_prod) : w_prod;

  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_abs_a = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_abs_b = (w_signed && B[WIDTH-1]) ? -B : B;

  // Restoring step: remainder < divisor holds, so the difference fits in WIDTH bits
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next, w_quo_next, w_q_final, w_r_final;
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_final  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final  = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !req) begin
          w_accept     = 1'b1;
          w_state_next = w_is_div ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == c_CNT_ONE) begin
          w_commit     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_temp  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dzero <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (!req && op == c_OP_MTHI) r_hi <= A;
      if (!req && op == c_OP_MTLO) r_lo <= A;
      if (w_accept) begin
        r_busy <= 1'b1;
        if (w_is_div) begin
          r_cnt   <= c_CNT_DIV;
          r_rem   <= '0;
          r_quo   <= w_abs_a;
          r_div   <= w_abs_b;
          r_neg_q <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          r_neg_r <= w_signed && A[WIDTH-1];
          r_dzero <= (B == '0);
        end else begin
          r_cnt  <= c_CNT_MUL;
          r_temp <= w_mul_res;
        end
      end
    end else begin
      r_cnt <= r_cnt - c_CNT_ONE;
      if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end
      if (w_commit) begin
        r_busy <= 1'b0;
        if (r_state == S_MUL) begin
          {r_hi, r_lo} <= r_temp;
        end else if (!r_dzero) begin
          r_lo <= w_q_final;
          r_hi <= w_r_final;
        end else if (c_DZ_Q) begin
          // Remainder register has shifted in |A|; the fixup restores the dividend
          r_lo <= '1;
          r_hi <= w_r_final;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e_mdu_iter.sv
//==============================================================================
// Module      : tb_e_mdu_iter
// Description : Directed self-checking bench for e_mdu_iter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_e_mdu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  op = '0;
  logic [31:0] result;
  logic        busy;
  logic        start;

  int total = 0;
  int bad   = 0;

  e_mdu_iter #(.WIDTH(32), .MULT_CYCLES(5), .DIV_ZERO_Q(1)) dut (
    .clk(clk), .reset(reset), .req(req), .A(A), .B(B), .op(op),
    .result(result), .busy(busy), .start(start)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; A = a; B = b;
    @(posedge clk);
    #1;
    op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    op = 4'd5; #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", result); end
    op = 4'd6; #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", result); end
    op = 4'd1; #1;
    total++; if (start !== 1'b1) begin bad++; $display("FAIL start_mult got=%b want=1", start); end
    op = 4'd5; #1;
    total++; if (start !== 1'b0) begin bad++; $display("FAIL start_mfhi got=%b want=0", start); end
    op = 4'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    do_op(4'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    total++; if (n !== 5) begin bad++; $display("FAIL mult_busy got=%0d want=5", n); end
    op = 4'd5; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", result); end
    op = 4'd6; #1;
    total++; if (result !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h want=fffffff1", result); end
    op = 4'd0;
  endtask

  task automatic test_divu;
    int n;
    do_op(4'd7, 32'h55, 32'd0);
    do_op(4'd4, 32'd100, 32'd7);
    op = 4'd5; #1;
    total++; if (result !== 32'h55) begin bad++; $display("FAIL divu_mid_hi got=%h want=55", result); end
    op = 4'd0;
    wait_idle(n);
    total++; if (n !== 32) begin bad++; $display("FAIL divu_busy got=%0d want=32", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=e", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=2", result); end
    op = 4'd0;
  endtask

  task automatic test_div_signed;
    int n;
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    op = 4'd6; #1;
    total++; if (result !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h want=fffffffd", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got=%h want=ffffffff", result); end
    op = 4'd0;
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    total++; if (n !== 32) begin bad++; $display("FAIL div_min_busy got=%0d want=32", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL div_min_lo got=%h want=80000000", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL div_min_hi got=%h want=0", result); end
    op = 4'd0;
  endtask

  task automatic test_div_zero;
    int n;
    do_op(4'd4, 32'd1234, 32'd0);
    wait_idle(n);
    total++; if (n !== 32) begin bad++; $display("FAIL dz_busy got=%0d want=32", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got=%h want=ffffffff", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'd1234) begin bad++; $display("FAIL dz_hi got=%h want=4d2", result); end
    op = 4'd0;
  endtask

  task automatic test_madd_msub;
    int n;
    do_op(4'd7, 32'd0, 32'd0);
    do_op(4'd8, 32'd10, 32'd0);
    do_op(4'd9, 32'd3, 32'd4);
    wait_idle(n);
    total++; if (n !== 5) begin bad++; $display("FAIL madd_busy got=%0d want=5", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'd22) begin bad++; $display("FAIL madd_lo got=%h want=16", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL madd_hi got=%h want=0", result); end
    op = 4'd0;
    do_op(4'd12, 32'd1, 32'd23);
    wait_idle(n);
    op = 4'd5; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msubu_hi got=%h want=ffffffff", result); end
    op = 4'd6; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msubu_lo got=%h want=ffffffff", result); end
    op = 4'd0;
  endtask

  task automatic test_req;
    req = 1'b1;
    do_op(4'd1, 32'd2, 32'd2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL req_busy got=%b want=0", busy); end
    do_op(4'd7, 32'h12, 32'd0);
    req = 1'b0;
    op = 4'd5; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL req_hi got=%h want=ffffffff", result); end
    op = 4'd6; #1;
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL req_lo got=%h want=ffffffff", result); end
    op = 4'd0;
  endtask

  task automatic test_reset_mid;
    int n;
    do_op(4'd4, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    op = 4'd5; #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rmid_hi got=%h want=0", result); end
    op = 4'd6; #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rmid_lo got=%h want=0", result); end
    op = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    do_op(4'd4, 32'd100, 32'd7);
    wait_idle(n);
    total++; if (n !== 32) begin bad++; $display("FAIL rmid_busy2 got=%0d want=32", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'd14) begin bad++; $display("FAIL rmid_lo2 got=%h want=e", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'd2) begin bad++; $display("FAIL rmid_hi2 got=%h want=2", result); end
    op = 4'd0;
  endtask

  task automatic test_back_to_back;
    int n;
    do_op(4'd2, 32'd2, 32'd3);
    op = 4'd8; A = 32'h77;
    repeat (2) @(posedge clk);
    #1 op = 4'd0;
    wait_idle(n);
    total++; if (n !== 3) begin bad++; $display("FAIL b2b_busy_rest got=%0d want=3", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'd6) begin bad++; $display("FAIL b2b_lo got=%h want=6", result); end
    op = 4'd5; #1;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%h want=0", result); end
    op = 4'd0;
    do_op(4'd1, 32'd4, 32'd5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_idle(n);
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_busy2 got=%0d want=5", n); end
    op = 4'd6; #1;
    total++; if (result !== 32'd20) begin bad++; $display("FAIL b2b_lo2 got=%h want=14", result); end
    op = 4'd0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_madd_msub();
    test_req();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
